uc_coordena_fases_param: RTL and testbench

Parametrised successor of the two-phase shot/asteroid coordinator control unit. It sequences N_CANAIS object classes (shots, asteroids, power-ups, …) in ascending channel order. Each channel runs an alternating compare → move loop a per-channel number of times, using start-pulse/done-level handshakes with lower-hierarchy FSMs. It adds internal step counters, a channel-enable mask, abort, and a per-wait watchdog with an error state. The main game FSM triggers it once per frame and waits for `fim`.

---
 rtl/uc_coordena_fases_param_pkg.sv | 20 ++
 rtl/uc_coordena_fases_param_seletor.sv | 24 ++
 rtl/uc_coordena_fases_param.sv | 168 ++++++++++++++++
 tb/tb_uc_coordena_fases_param.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uc_coordena_fases_param_pkg.sv
// State encodings shared by the phase coordinator FSM and its debug state output.
package pkg_uc_coordena;

  localparam int EST_W = 5;

  typedef enum logic [EST_W-1:0] {
    INICIO         = 5'd0,
    ESPERA         = 5'd1,
    CARREGA        = 5'd2,
    SELECIONA      = 5'd3,
    COMPARA        = 5'd4,
    ESPERA_COMPARA = 5'd5,
    MOVE           = 5'd6,
    ESPERA_MOVE    = 5'd7,
    PROXIMO        = 5'd8,
    FIM            = 5'd9,
    ERRO           = 5'd15
  } estado_t;

endpackage

// File: rtl/uc_coordena_fases_param_seletor.sv
// Priority encoder: lowest enabled channel index at or above a start index.
module seletor_canal_habilitado #(
  parameter int N_CANAIS = 2,
  parameter int CH_W     = 1
) (
  input  logic [N_CANAIS-1:0] mask,
  input  logic [CH_W-1:0]     base,
  output logic                achou,
  output logic [CH_W-1:0]     indice
);

  // Scan downward so the lowest qualifying channel is the last one written.
  always_comb begin
    achou  = 1'b0;
    indice = '0;
    for (int i = N_CANAIS - 1; i >= 0; i--) begin
      if (mask[i] && (i >= int'(base))) begin
        achou  = 1'b1;
        indice = CH_W'(i);
      end
    end
  end

endmodule

// File: rtl/uc_coordena_fases_param.sv
// Per-frame coordinator: walks enabled channels in order, alternating compare/move
// handshakes with lower FSMs, with abort and a per-wait watchdog.
module uc_coordena_fases_param
  import pkg_uc_coordena::*;
#(
  parameter int N_CANAIS  = 2,
  parameter int CNT_W     = 4,
  parameter int TIMEOUT_W = 8,
  parameter int CH_W      = (N_CANAIS > 1) ? $clog2(N_CANAIS) : 1
) (
  input  logic                      clock,
  input  logic                      reset_n,
  input  logic                      inicia,
  input  logic                      aborta,
  input  logic [N_CANAIS-1:0]       habilita_canal,
  input  logic [N_CANAIS*CNT_W-1:0] passos,
  input  logic [N_CANAIS-1:0]       fim_compara,
  input  logic [N_CANAIS-1:0]       fim_move,
  output logic [N_CANAIS-1:0]       compara,
  output logic [N_CANAIS-1:0]       move,
  output logic                      ocupado,
  output logic                      fim,
  output logic                      erro,
  output logic [CH_W-1:0]           canal_atual,
  output logic [CNT_W-1:0]          passo_atual,
  output logic [4:0]                db_estado
);

  localparam logic [TIMEOUT_W-1:0] WD_MAX    = '1;
  localparam logic [CH_W-1:0]      ULTIMO_CH = CH_W'(N_CANAIS - 1);

  estado_t                        estado, prox;
  logic [N_CANAIS-1:0]            mask_q;
  logic [N_CANAIS-1:0][CNT_W-1:0] passos_q;
  logic [CH_W-1:0]                canal, canal_prox;
  logic [CNT_W-1:0]               passo, passo_prox;
  logic [TIMEOUT_W-1:0]           wd, wd_prox, wd_inc;
  logic                           sel_achou;
  logic [CH_W-1:0]                sel_indice;
  logic                           done_cmp, done_mov, wd_estoura;

  seletor_canal_habilitado #(
    .N_CANAIS (N_CANAIS),
    .CH_W     (CH_W)
  ) u_seletor (
    .mask   (mask_q),
    .base   (canal),
    .achou  (sel_achou),
    .indice (sel_indice)
  );

  // Only the current channel's done level matters; others are ignored.
  assign done_cmp   = fim_compara[canal];
  assign done_mov   = fim_move[canal];
  assign wd_inc     = wd + 1'b1;
  assign wd_estoura = (wd_inc == WD_MAX);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      estado   <= INICIO;
      canal    <= '0;
      passo    <= '0;
      wd       <= '0;
      mask_q   <= '0;
      passos_q <= '0;
    end else begin
      estado <= prox;
      canal  <= canal_prox;
      passo  <= passo_prox;
      wd     <= wd_prox;
      if (estado == CARREGA) begin
        mask_q   <= habilita_canal;
        passos_q <= passos;
      end
    end
  end

  always_comb begin
    prox       = estado;
    canal_prox = canal;
    passo_prox = passo;
    wd_prox    = wd;
    compara    = '0;
    move       = '0;
    ocupado    = 1'b1;
    fim        = 1'b0;
    erro       = 1'b0;
    case (estado)
      INICIO: begin
        ocupado = 1'b0;
        prox    = ESPERA;
      end
      ESPERA: begin
        ocupado = 1'b0;
        if (inicia) prox = CARREGA;
      end
      CARREGA: begin
        canal_prox = '0;
        passo_prox = '0;
        prox       = SELECIONA;
      end
      SELECIONA: begin
        if (sel_achou) begin
          canal_prox = sel_indice;
          passo_prox = '0;
          prox       = COMPARA;
        end else begin
          prox = FIM;
        end
      end
      COMPARA: begin
        compara[canal] = 1'b1;
        wd_prox        = '0;
        prox           = ESPERA_COMPARA;
      end
      ESPERA_COMPARA: begin
        wd_prox = wd_inc;
        // Done on the watchdog's final edge still counts as completion.
        if (done_cmp) begin
          if (passo != passos_q[canal]) begin
            prox = MOVE;
          end else if (canal == ULTIMO_CH) begin
            prox = FIM;
          end else begin
            canal_prox = canal + 1'b1;
            prox       = SELECIONA;
          end
        end else if (wd_estoura) begin
          prox = ERRO;
        end
      end
      MOVE: begin
        move[canal] = 1'b1;
        wd_prox     = '0;
        prox        = ESPERA_MOVE;
      end
      ESPERA_MOVE: begin
        wd_prox = wd_inc;
        if (done_mov)        prox = PROXIMO;
        else if (wd_estoura) prox = ERRO;
      end
      PROXIMO: begin
        passo_prox = passo + 1'b1;
        prox       = COMPARA;
      end
      FIM: begin
        fim  = 1'b1;
        prox = ESPERA;
      end
      ERRO: begin
        ocupado = 1'b0;
        erro    = 1'b1;
        if (inicia) prox = CARREGA;
      end
      default: begin
        ocupado = 1'b0;
        prox    = INICIO;
      end
    endcase
    // Abort overrides done and timeout in every busy state.
    if (aborta && ocupado) prox = ESPERA;
  end

  assign canal_atual = canal;
  assign passo_atual = passo;
  assign db_estado   = estado;

endmodule

// File: tb/tb_uc_coordena_fases_param.sv
// Self-checking bench: randomized and directed runs against a sequence/timing model.
module tb_uc_coordena_fases_param;

  localparam int N  = 3;
  localparam int CW = 4;
  localparam int TW = 8;
  localparam int HW = 2;

  logic          clock = 1'b0;
  logic          reset_n;
  logic          inicia, aborta;
  logic [N-1:0]  habilita_canal;
  logic [N*CW-1:0] passos;
  logic [N-1:0]  fim_compara, fim_move;
  logic [N-1:0]  compara, move;
  logic          ocupado, fim, erro;
  logic [HW-1:0] canal_atual;
  logic [CW-1:0] passo_atual;
  logic [4:0]    db_estado;

  uc_coordena_fases_param #(
    .N_CANAIS (N),
    .CNT_W    (CW),
    .TIMEOUT_W(TW)
  ) dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .inicia         (inicia),
    .aborta         (aborta),
    .habilita_canal (habilita_canal),
    .passos         (passos),
    .fim_compara    (fim_compara),
    .fim_move       (fim_move),
    .compara        (compara),
    .move           (move),
    .ocupado        (ocupado),
    .fim            (fim),
    .erro           (erro),
    .canal_atual    (canal_atual),
    .passo_atual    (passo_atual),
    .db_estado      (db_estado)
  );

  always #5 clock = ~clock;

  // Lower-hierarchy responder: done level rises some cycles after each start pulse.
  bit           resp_on    = 1'b1;
  bit           resp_noise = 1'b0;
  int           resp_delay = 2;
  logic [N-1:0] fc_r = '0, fm_r = '0, fc_man = '0, fm_man = '0;
  int           cnt_c[N], cnt_m[N];

  assign fim_compara = resp_on ? fc_r : fc_man;
  assign fim_move    = resp_on ? fm_r : fm_man;

  always @(negedge clock) begin
    for (int c = 0; c < N; c++) begin
      if (compara[c]) begin
        fc_r[c]  = 1'b0;
        cnt_c[c] = (resp_delay == 0) ? int'($urandom_range(1, 4)) : resp_delay;
      end else if (cnt_c[c] > 0) begin
        cnt_c[c]--;
        if (cnt_c[c] == 0) fc_r[c] = 1'b1;
      end else if (resp_noise && c != int'(canal_atual)) begin
        fc_r[c] = 1'($urandom_range(0, 1));
      end
      if (move[c]) begin
        fm_r[c]  = 1'b0;
        cnt_m[c] = (resp_delay == 0) ? int'($urandom_range(1, 4)) : resp_delay;
      end else if (cnt_m[c] > 0) begin
        cnt_m[c]--;
        if (cnt_m[c] == 0) fm_r[c] = 1'b1;
      end else if (resp_noise && c != int'(canal_atual)) begin
        fm_r[c] = 1'($urandom_range(0, 1));
      end
    end
  end

  int n_assert = 0, n_fail = 0;
  int cyc = 0, t_start = 0, t_fim = -1, nfim = 0;
  int ev_q[$], tq[$], exp_q[$], exp_t[$];
  int exp_fim;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic int enc(input int tipo, input int ch, input int cn, input int ps);
    return (tipo << 12) | (ch << 8) | (cn << 4) | ps;
  endfunction

  function automatic int idx1(input logic [N-1:0] v);
    if ($countones(v) != 1) return 15;
    for (int i = 0; i < N; i++) if (v[i]) return i;
    return 15;
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
    cyc++;
    if (|compara) begin
      ev_q.push_back(enc(0, idx1(compara), int'(canal_atual), int'(passo_atual)));
      tq.push_back(cyc - t_start);
    end
    if (|move) begin
      ev_q.push_back(enc(1, idx1(move), int'(canal_atual), int'(passo_atual)));
      tq.push_back(cyc - t_start);
    end
    if (fim) begin
      nfim++;
      t_fim = cyc - t_start;
    end
  endtask

  // Expected pulse order and relative timing from the channel/step rules.
  task automatic build_exp(input logic [N-1:0] m, input logic [N*CW-1:0] p, input int d);
    int n, pt, ct, lc;
    exp_q.delete();
    exp_t.delete();
    for (int c = 0; c < N; c++) begin
      if (m[c]) begin
        n = int'(p[c*CW +: CW]);
        for (int s = 0; s <= n; s++) begin
          exp_q.push_back(enc(0, c, c, s));
          if (s < n) exp_q.push_back(enc(1, c, c, s));
        end
      end
    end
    if (exp_q.size() == 0) begin
      exp_fim = 2;
    end else begin
      exp_t.push_back(2);
      for (int i = 1; i < exp_q.size(); i++) begin
        pt = exp_q[i-1] >> 12;
        ct = exp_q[i] >> 12;
        exp_t.push_back(exp_t[i-1] + ((pt == 0 && ct == 1) ? d + 1 : d + 2));
      end
      lc = (exp_q[exp_q.size()-1] >> 8) & 15;
      exp_fim = exp_t[exp_t.size()-1] + ((lc == N - 1) ? d + 1 : d + 2);
    end
  endtask

  task automatic start(input logic [N-1:0] m, input logic [N*CW-1:0] p);
    ev_q.delete();
    tq.delete();
    nfim = 0;
    t_fim = -1;
    habilita_canal = m;
    passos = p;
    inicia = 1'b1;
    tick();
    t_start = cyc;
  endtask

  // inicia stays high through the run and must be ignored while busy.
  task automatic run_check(input string tag, input logic [N-1:0] m, input logic [N*CW-1:0] p,
                           input int d, input bit noise);
    bit ok = 1'b0;
    resp_delay = d;
    resp_noise = noise;
    start(m, p);
    build_exp(m, p, d);
    for (int i = 0; i < 800; i++) begin
      if (i == 1) begin
        habilita_canal = N'($urandom_range(0, 7));
        passos = (N*CW)'($urandom);
      end
      tick();
      if (fim) inicia = 1'b0;
      if (db_estado == 5'd1) begin
        ok = 1'b1;
        break;
      end
    end
    inicia = 1'b0;
    resp_noise = 1'b0;
    chk({tag, "_done"}, 32'(ok), 32'd1);
    chk({tag, "_nev"}, ev_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < ev_q.size(); i++) begin
      chk($sformatf("%s_ev%0d", tag, i), ev_q[i], exp_q[i]);
      if (d > 0) chk($sformatf("%s_t%0d", tag, i), tq[i], exp_t[i]);
    end
    chk({tag, "_nfim"}, nfim, 1);
    if (d > 0) chk({tag, "_tfim"}, t_fim, exp_fim);
  endtask

  initial begin
    int n;
    logic [N-1:0] m;
    logic [N*CW-1:0] p;
    reset_n = 1'b0;
    inicia = 1'b0;
    aborta = 1'b0;
    habilita_canal = '0;
    passos = '0;
    #12;
    chk("rst_state", db_estado, 5'd0);
    chk("rst_outs", {compara, move, ocupado, fim, erro, canal_atual, passo_atual}, 0);
    #1 reset_n = 1'b1;
    #1 chk("inicio_hold", db_estado, 5'd0);
    tick();
    chk("inicio_to_espera", db_estado, 5'd1);

    run_check("two_ch", 3'b011, 12'h023, 2, 1'b0);
    run_check("skip_ch1", 3'b101, 12'h111, 1, 1'b0);
    run_check("empty", 3'b000, 12'h333, 2, 1'b0);

    for (int r = 0; r < 8; r++) begin
      m = N'($urandom_range(0, 7));
      p = {4'($urandom_range(0, 3)), 4'($urandom_range(0, 3)), 4'($urandom_range(0, 3))};
      run_check($sformatf("rnd%0d", r), m, p, (r % 2 == 1) ? 0 : int'($urandom_range(1, 3)), r >= 2);
    end

    // Non-current done held high must not help; watchdog expires after 255 waiting cycles.
    resp_on = 1'b0;
    fc_man = 3'b010;
    fm_man = '0;
    start(3'b011, 12'h011);
    inicia = 1'b0;
    for (int i = 0; i < 20 && db_estado != 5'd5; i++) tick();
    n = 0;
    while (db_estado == 5'd5 && n < 400) begin
      n++;
      tick();
    end
    chk("wd_cycles", n, 255);
    chk("wd_state", db_estado, 5'd15);
    chk("wd_erro", erro, 1'b1);
    chk("wd_ocupado", ocupado, 1'b0);
    tick();
    tick();
    chk("erro_hold", db_estado, 5'd15);
    inicia = 1'b1;
    tick();
    inicia = 1'b0;
    chk("erro_restart", db_estado, 5'd2);
    chk("restart_erro_low", erro, 1'b0);
    aborta = 1'b1;
    tick();
    aborta = 1'b0;
    chk("abort_carrega", db_estado, 5'd1);

    // Done arriving on the last allowed waiting cycle still wins.
    fc_man = '0;
    start(3'b001, 12'h000);
    inicia = 1'b0;
    for (int i = 0; i < 20 && db_estado != 5'd5; i++) tick();
    n = 1;
    while (n < 255) begin
      tick();
      n++;
    end
    chk("wd_edge_wait", db_estado, 5'd5);
    fc_man = 3'b001;
    tick();
    chk("wd_edge_done", db_estado, 5'd3);
    fc_man = '0;
    tick();
    chk("wd_edge_fim", {db_estado, fim}, {5'd9, 1'b1});
    tick();
    chk("wd_edge_back", db_estado, 5'd1);
    resp_on = 1'b1;

    // Abort while channel 1 waits on its move.
    resp_delay = 3;
    start(3'b011, 12'h011);
    build_exp(3'b011, 12'h011, 3);
    for (int i = 0; i < 200; i++) begin
      if (db_estado == 5'd7 && canal_atual == 2'd1) break;
      tick();
    end
    chk("abort_reached", {db_estado, canal_atual}, {5'd7, 2'd1});
    aborta = 1'b1;
    inicia = 1'b0;
    tick();
    aborta = 1'b0;
    chk("abort_espera", db_estado, 5'd1);
    chk("abort_ocupado", ocupado, 1'b0);
    for (int i = 0; i < 10; i++) tick();
    chk("abort_nev", ev_q.size(), 5);
    for (int i = 0; i < 5 && i < ev_q.size(); i++) chk($sformatf("abort_ev%0d", i), ev_q[i], exp_q[i]);
    chk("abort_nfim", nfim, 0);

    // Asynchronous reset between edges while in COMPARA.
    resp_delay = 0;
    start(3'b110, 12'h220);
    for (int i = 0; i < 200; i++) begin
      if (db_estado == 5'd4 && canal_atual == 2'd2) break;
      tick();
    end
    chk("mid_compara", {db_estado, compara}, {5'd4, 3'b100});
    #2 reset_n = 1'b0;
    inicia = 1'b0;
    #1;
    chk("async_state", db_estado, 5'd0);
    chk("async_outs", {compara, move, ocupado, fim, erro, canal_atual, passo_atual}, 0);
    #2 reset_n = 1'b1;
    tick();
    chk("post_rst_espera", db_estado, 5'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
